// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   owner_e      : identifies the last grantee of the data memory
//   MEM_*        : mem_acc_mode encodings shared with data_mem
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

   // mem_acc_mode: bit 2 selects unsigned extension, bits 1:0 select size
   localparam logic [2:0] MEM_BYTE   = 3'b000;
   localparam logic [2:0] MEM_HALF   = 3'b001;
   localparam logic [2:0] MEM_WORD   = 3'b010;
   localparam logic [2:0] MEM_BYTE_U = 3'b100;
   localparam logic [2:0] MEM_HALF_U = 3'b101;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//   req0, req1 : request lines
//   last       : 1 = requester 1 was granted most recently, 0 = requester 0
//   gnt[1:0]   : one-hot grant (bit 0 -> req0, bit 1 -> req1), 0 if idle
// A lone requester always wins; on a conflict the one not granted last wins.
// -----------------------------------------------------------------------------
module rr_pick2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req0 && req1) begin
         gnt = last ? 2'b01 : 2'b10;
      end else begin
         gnt = {req1, req0};
      end
   end

endmodule : rr_pick2

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported data memory between the core load/store path and a
// DMA/loader port. One access per cycle, round-robin on conflicts, with locked
// DMA bursts that the core may interrupt for one beat after MAX_BURST beats.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   core_req/we/addr/wdata/mode  : core request (held until core_gnt)
//   core_gnt, core_rdata         : core grant and load data (0 if not granted)
//   core_stall                   : core_req & ~core_gnt, freezes PC / rf write
//   dma_req/we/addr/wdata/mode   : DMA request (may drop before grant = abort)
//   dma_last                     : current DMA beat ends its burst
//   dma_gnt, dma_rdata           : DMA grant and load data (0 if not granted)
//   mem_rd_en/wr_en/addr/wdata/acc_mode : drive to data_mem
//   mem_rdata                    : combinational read data from data_mem
// All outputs are combinational from inputs and registered state; they are
// forced to 0 while rst is high.
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        core_req,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic [2:0]  core_mode,
   output logic        core_gnt,
   output logic [31:0] core_rdata,
   output logic        core_stall,

   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic [2:0]  dma_mode,
   input  logic        dma_last,
   output logic        dma_gnt,
   output logic [31:0] dma_rdata,

   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_acc_mode,
   input  logic [31:0] mem_rdata
);

   localparam int            BEAT_W   = $clog2(MAX_BURST + 1);
   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

   owner_e              last_q, last_d;
   logic                lock_q, lock_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;

   logic [1:0]          rr_gnt;
   logic                steal;
   logic                gnt_core;
   logic                gnt_dma;

   // Unlocked arbitration: lone requester wins, else alternate.
   rr_pick2 u_rr_pick2 (
      .req0 (core_req),
      .req1 (dma_req),
      .last (last_q == OWN_DMA),
      .gnt  (rr_gnt)
   );

   // ---------------------------------------------------------------------------
   // Grant selection
   // ---------------------------------------------------------------------------
   assign steal = lock_q && dma_req && core_req && (beat_q == BEAT_MAX);

   always_comb begin
      gnt_core = 1'b0;
      gnt_dma  = 1'b0;
      if (!rst) begin
         if (steal) begin
            gnt_core = 1'b1;
         end else if (lock_q && dma_req) begin
            gnt_dma = 1'b1;
         end else begin
            gnt_core = rr_gnt[0];
            gnt_dma  = rr_gnt[1];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Memory drive and read-data routing
   // ---------------------------------------------------------------------------
   always_comb begin
      mem_rd_en    = 1'b0;
      mem_wr_en    = 1'b0;
      mem_addr     = 32'd0;
      mem_wdata    = 32'd0;
      mem_acc_mode = 3'd0;
      core_rdata   = 32'd0;
      dma_rdata    = 32'd0;
      if (gnt_core) begin
         mem_wr_en    = core_we;
         mem_rd_en    = ~core_we;
         mem_addr     = core_addr;
         mem_wdata    = core_wdata;
         mem_acc_mode = core_mode;
         core_rdata   = mem_rdata;
      end else if (gnt_dma) begin
         mem_wr_en    = dma_we;
         mem_rd_en    = ~dma_we;
         mem_addr     = dma_addr;
         mem_wdata    = dma_wdata;
         mem_acc_mode = dma_mode;
         dma_rdata    = mem_rdata;
      end
   end

   assign core_gnt   = gnt_core;
   assign dma_gnt    = gnt_dma;
   assign core_stall = core_req & ~gnt_core & ~rst;

   // ---------------------------------------------------------------------------
   // Next-state: owner, burst lock and beat counter
   // ---------------------------------------------------------------------------
   always_comb begin
      last_d = last_q;
      lock_d = lock_q;
      beat_d = beat_q;

      if (gnt_core) begin
         last_d = OWN_CORE;
      end else if (gnt_dma) begin
         last_d = OWN_DMA;
      end

      if (steal) begin
         // Stolen beat: the lock survives so DMA resumes next cycle, and the
         // count restarts so DMA gets another full window.
         beat_d = '0;
      end else if (gnt_dma) begin
         if (dma_last) begin
            lock_d = 1'b0;
            beat_d = '0;
         end else if (!lock_q) begin
            // The beat that opens the burst is the first beat of the window.
            lock_d = 1'b1;
            beat_d = BEAT_W'(1);
         end else if (beat_q != BEAT_MAX) begin
            beat_d = beat_q + BEAT_W'(1);
         end
      end else if (lock_q && !dma_req) begin
         // DMA dropped its request mid-burst: abandon the burst.
         lock_d = 1'b0;
         beat_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= OWN_DMA;
         lock_q <= 1'b0;
         beat_q <= '0;
      end else begin
         last_q <= last_d;
         lock_q <= lock_d;
         beat_q <= beat_d;
      end
   end

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        core_req, core_we;
   logic [31:0] core_addr, core_wdata;
   logic [2:0]  core_mode;
   logic        core_gnt, core_stall;
   logic [31:0] core_rdata;
   logic        dma_req, dma_we, dma_last;
   logic [31:0] dma_addr, dma_wdata;
   logic [2:0]  dma_mode;
   logic        dma_gnt;
   logic [31:0] dma_rdata;
   logic        mem_rd_en, mem_wr_en;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_acc_mode;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_mode(core_mode),
      .core_gnt(core_gnt), .core_rdata(core_rdata), .core_stall(core_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_mode(dma_mode), .dma_last(dma_last),
      .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_acc_mode(mem_acc_mode), .mem_rdata(mem_rdata)
   );

   // Word-wide data memory stand-in: combinational read, write at posedge.
   logic [31:0] mem [256];
   logic        tb_init = 1'b1;
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
         mem[32] <= 32'h1234_5678;            // address 0x80
      end else if (mem_wr_en) begin
         mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   typedef struct packed {
      logic        rst;
      logic        c_req, c_we;
      logic [31:0] c_addr, c_wdata;
      logic        d_req, d_we;
      logic [31:0] d_addr, d_wdata;
      logic        d_last;
      logic        e_cg, e_dg, e_st, e_rd, e_wr;
      logic [31:0] e_addr, e_crd, e_drd;
   } vec_t;

   vec_t vt [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic cr, input logic cw,
                        input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dd, input logic dl);
      rst = r; core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
      dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_last = dl;
   endtask

   // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(logic r, logic cr, logic cw, logic [31:0] ca, logic [31:0] cd,
                               logic dr, logic dw, logic [31:0] da, logic [31:0] dd, logic dl,
                               logic cg, logic dg, logic st, logic rd, logic wr,
                               logic [31:0] ea, logic [31:0] ecr, logic [31:0] edr);
      vec_t v;
      v.rst = r; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
      v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd; v.d_last = dl;
      v.e_cg = cg; v.e_dg = dg; v.e_st = st; v.e_rd = rd; v.e_wr = wr;
      v.e_addr = ea; v.e_crd = ecr; v.e_drd = edr;
      return v;
   endfunction

   logic exp_dma [12];
   int   beat;

   initial begin
      core_mode = 3'b010;
      dma_mode  = 3'b010;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      tb_init = 1'b0;

      //            rst c_req we addr          wdata         d_req we addr          wdata         last  cg dg st rd wr addr          core_rdata    dma_rdata
      vt[0]  = mk(1, 1, 0, 32'h40, 32'h0,         1, 0, 32'h80, 32'h0,         1,    0, 0, 0, 0, 0, 32'h0,  32'h0,         32'h0);
      vt[1]  = mk(0, 0, 0, 32'h0,  32'h0,         0, 0, 32'h0,  32'h0,         0,    0, 0, 0, 0, 0, 32'h0,  32'h0,         32'h0);
      vt[2]  = mk(0, 1, 1, 32'h40, 32'hDEADBEEF,  1, 0, 32'h80, 32'h0,         1,    1, 0, 0, 0, 1, 32'h40, 32'h0,         32'h0);
      vt[3]  = mk(0, 1, 0, 32'h40, 32'h0,         1, 0, 32'h80, 32'h0,         1,    0, 1, 1, 1, 0, 32'h80, 32'h0,         32'h12345678);
      vt[4]  = mk(0, 1, 0, 32'h40, 32'h0,         1, 0, 32'h80, 32'h0,         1,    1, 0, 0, 1, 0, 32'h40, 32'hDEADBEEF,  32'h0);
      vt[5]  = mk(0, 0, 0, 32'h0,  32'h0,         1, 0, 32'h80, 32'h0,         1,    0, 1, 0, 1, 0, 32'h80, 32'h0,         32'h12345678);
      vt[6]  = mk(0, 1, 0, 32'h40, 32'h0,         0, 0, 32'h0,  32'h0,         0,    1, 0, 0, 1, 0, 32'h40, 32'hDEADBEEF,  32'h0);
      vt[7]  = mk(0, 1, 0, 32'h40, 32'h0,         1, 1, 32'h84, 32'hA5A5A5A5,  1,    0, 1, 1, 0, 1, 32'h84, 32'h0,         32'h0);
      vt[8]  = mk(0, 1, 0, 32'h40, 32'h0,         0, 0, 32'h0,  32'h0,         0,    1, 0, 0, 1, 0, 32'h40, 32'hDEADBEEF,  32'h0);
      vt[9]  = mk(0, 0, 1, 32'h44, 32'h11111111,  0, 1, 32'h88, 32'h22222222,  1,    0, 0, 0, 0, 0, 32'h0,  32'h0,         32'h0);
      vt[10] = mk(0, 0, 0, 32'h0,  32'h0,         1, 0, 32'h84, 32'h0,         1,    0, 1, 0, 1, 0, 32'h84, 32'h0,         32'hA5A5A5A5);

      for (int i = 0; i < 11; i++) begin
         drive(vt[i].rst, vt[i].c_req, vt[i].c_we, vt[i].c_addr, vt[i].c_wdata,
               vt[i].d_req, vt[i].d_we, vt[i].d_addr, vt[i].d_wdata, vt[i].d_last);
         @(negedge clk);
         chk($sformatf("vec%0d core_gnt", i),   {31'd0, core_gnt},   {31'd0, vt[i].e_cg});
         chk($sformatf("vec%0d dma_gnt", i),    {31'd0, dma_gnt},    {31'd0, vt[i].e_dg});
         chk($sformatf("vec%0d core_stall", i), {31'd0, core_stall}, {31'd0, vt[i].e_st});
         chk($sformatf("vec%0d mem_rd_en", i),  {31'd0, mem_rd_en},  {31'd0, vt[i].e_rd});
         chk($sformatf("vec%0d mem_wr_en", i),  {31'd0, mem_wr_en},  {31'd0, vt[i].e_wr});
         chk($sformatf("vec%0d mem_addr", i),   mem_addr,            vt[i].e_addr);
         chk($sformatf("vec%0d core_rdata", i), core_rdata,          vt[i].e_crd);
         chk($sformatf("vec%0d dma_rdata", i),  dma_rdata,           vt[i].e_drd);
         next_cycle();
      end

      // ---- Burst of 10 with core held: D1-4, steal, D5-8, steal, D9-10 ----
      drive(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0);      // core alone: last = core
      @(negedge clk);
      chk("pre_burst core_gnt", {31'd0, core_gnt}, 32'd1);
      next_cycle();

      exp_dma = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
      beat = 0;
      for (int c = 0; c < 12; c++) begin
         drive(0, 1, 0, 32'h40, 0, 1, 1, 32'h100 + 32'(beat) * 4,
               32'hB000_0000 + 32'(beat), (beat == 9));
         @(negedge clk);
         chk($sformatf("burst c%0d dma_gnt", c),  {31'd0, dma_gnt},  {31'd0, exp_dma[c]});
         chk($sformatf("burst c%0d core_gnt", c), {31'd0, core_gnt}, {31'd0, ~exp_dma[c]});
         if (exp_dma[c])
            chk($sformatf("burst c%0d mem_addr", c), mem_addr, 32'h100 + 32'(beat) * 4);
         else
            chk($sformatf("burst c%0d steal rdata", c), core_rdata, 32'hDEADBEEF);
         if (dma_gnt) beat++;
         next_cycle();
      end
      // Lock must be gone: a fresh conflict goes to the core (last was DMA).
      drive(0, 1, 0, 32'h40, 0, 1, 0, 32'h100, 0, 1);
      @(negedge clk);
      chk("post_burst core_gnt", {31'd0, core_gnt}, 32'd1);
      chk("post_burst dma_gnt",  {31'd0, dma_gnt},  32'd0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 0, 32'h100, 0, 1);
      @(negedge clk);
      chk("post_burst dma_rdata", dma_rdata, 32'hB000_0000);
      next_cycle();

      // ---- Burst abort after beat 2 ----
      drive(0, 0, 0, 0, 0, 1, 0, 32'h200, 0, 0);
      @(negedge clk);
      chk("abort b1 dma_gnt", {31'd0, dma_gnt}, 32'd1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 0, 32'h204, 0, 0);
      @(negedge clk);
      chk("abort b2 dma_gnt", {31'd0, dma_gnt}, 32'd1);
      chk("abort b2 lock_q",  {31'd0, dut.lock_q}, 32'd1);
      chk("abort b2 beat_q",  32'(dut.beat_q), 32'd1);
      next_cycle();
      drive(0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("abort core_gnt",   {31'd0, core_gnt},   32'd1);
      chk("abort core_stall", {31'd0, core_stall}, 32'd0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("abort lock_q", {31'd0, dut.lock_q}, 32'd0);
      chk("abort beat_q", 32'(dut.beat_q), 32'd0);
      chk("idle mem_addr", mem_addr, 32'd0);
      chk("idle core_stall", {31'd0, core_stall}, 32'd0);
      next_cycle();

      // ---- Reset during DMA beat 3 ----
      for (int b = 0; b < 2; b++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 32'h300 + 32'(b) * 4, 0, 0);
         @(negedge clk);
         chk($sformatf("rstburst b%0d dma_gnt", b), {31'd0, dma_gnt}, 32'd1);
         next_cycle();
      end
      drive(1, 1, 0, 32'h40, 0, 1, 0, 32'h308, 0, 0);
      @(negedge clk);
      chk("rstburst dma_gnt",   {31'd0, dma_gnt},   32'd0);
      chk("rstburst core_gnt",  {31'd0, core_gnt},  32'd0);
      chk("rstburst stall",     {31'd0, core_stall}, 32'd0);
      chk("rstburst rd_en",     {31'd0, mem_rd_en}, 32'd0);
      chk("rstburst mem_addr",  mem_addr,           32'd0);
      next_cycle();
      drive(0, 1, 0, 32'h40, 0, 1, 0, 32'h308, 0, 0);
      @(negedge clk);
      chk("after_rst core_gnt", {31'd0, core_gnt}, 32'd1);
      chk("after_rst dma_gnt",  {31'd0, dma_gnt},  32'd0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 1, 0, 32'h308, 0, 1);
      @(negedge clk);
      chk("after_rst dma beat", {31'd0, dma_gnt}, 32'd1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_dmem_arbiter
